prod_accum: RTL and testbench
=============================

PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter WIDTH, default 16, is the operand width of the upstream multiplier; the product input is 2*WIDTH bits and the output is WIDTH bits.
REQ-002 Parameter ACC_LEN, default 8, is the number of products summed per result (legal range 2..256).
REQ-003 Parameter GUARD, default 8, is the number of accumulator guard bits (GUARD >= clog2(ACC_LEN)); the accumulator is 2*WIDTH+GUARD bits, signed.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 p_in  input  2*WIDTH  signed two's-complement product from the multiplier stage.
REQ-007 p_valid  input  1  p_in is valid this cycle.
REQ-008 in_ready  output  1  block can accept a product this cycle.
REQ-009 out_data  output  WIDTH  signed, rounded and scaled dot-product result.
REQ-010 out_valid  output  1  out_data holds a result.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 ovf  output  1  the current result was clipped (SAT_EN) or wrapped (no SAT_EN); valid while out_valid=1.
REQ-013 drop  output  1  sticky: a product arrived with p_valid=1 while in_ready=0.

Function
REQ-014 The FSM shall have states IDLE, ACC and DONE; in_ready=1 in IDLE and ACC, and 0 in DONE.
REQ-015 A product is accepted on a rising edge where p_valid=1 and in_ready=1; cnt counts accepted products in the current group.
REQ-016 On an accept in IDLE: acc = sext(p_in), cnt=1, and the next state is ACC (or DONE if ACC_LEN==1 is ever permitted).
REQ-017 On an accept in ACC: acc = acc + sext(p_in), cnt = cnt+1; on the ACC_LEN-th accept the next state is DONE.
REQ-018 Rounding: r = (acc_final + 2^(WIDTH-1)) >>> WIDTH (arithmetic shift, round-half-up), giving a WIDTH+GUARD-bit value.
REQ-019 out_data and ovf shall be registered and become valid in the cycle after the ACC_LEN-th accept, which gives a latency of 1 clock from the last accept to out_valid=1.
REQ-020 In DONE, out_valid=1 and out_data/ovf stay stable until out_ready=1 is sampled.
REQ-021 The transfer completes on a rising edge with out_valid=1 and out_ready=1; then acc=0, cnt=0 and the state returns to IDLE; in_ready=1 from the next cycle (no accept in the transfer cycle).
REQ-022 A product with p_valid=1 in DONE shall be discarded, leaving acc unchanged, and shall set drop=1; drop clears only on reset.
REQ-023 Gaps in p_valid while in ACC shall hold acc and cnt unchanged, with no timeout.
REQ-024 The accumulator shall never overflow internally, because GUARD bits cover ACC_LEN full-scale products.

Reset
REQ-025 While rst_n=0: state=IDLE, acc=0, cnt=0, out_data=0, out_valid=0, ovf=0, drop=0; in_ready=0 during reset and 1 from the first clock after release.
REQ-026 Reset asserted mid-group or in DONE shall abandon the partial or pending result with no output produced.

Configuration
REQ-027 Macro PROD_ACCUM_SAT_EN: when defined, a value r outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] shall clip to 0x7FF..F or 0x800..0 and set ovf=1.
REQ-028 Without PROD_ACCUM_SAT_EN: out_data = r[WIDTH-1:0] (wrap-around), and ovf=1 when the discarded upper bits are not the sign extension.

Verification (WIDTH=16, ACC_LEN=4, GUARD=8)
REQ-029 Basic: four products 0x00010000, back-to-back -> one cycle after the 4th accept out_valid=1, out_data=0x0004, ovf=0.
REQ-030 Rounding: products 0x00008000, 0, 0, 0 -> out_data=0x0001; products 0xFFFF7FFF, 0, 0, 0 -> out_data=0xFFFF.
REQ-031 Overflow: four products 0x40000000 -> SAT_EN: out_data=0x7FFF, ovf=1; no SAT_EN: out_data=0x0000, ovf=1. Four products 0xC0000000 -> SAT_EN: 0x8000, ovf=1.
REQ-032 Backpressure: out_ready=0 for 3 cycles after out_valid rises, with a p_valid pulse in that window -> out_data stable, in_ready=0, drop=1; after the transfer, the next group of four 0x00010000 still yields 0x0004.
REQ-033 Gapped input: four 0x00010000 products with 2 idle cycles between each -> out_data=0x0004; out_valid never rises early.
REQ-034 Reset mid-group: after 2 accepts, pulse rst_n low asynchronously between edges -> all outputs 0 immediately; a following clean group of four 0x00010000 yields 0x0004.

Source files
------------

// File: rtl/prod_accum_if.sv
// Handshake bundle between the multiplier stage, the product accumulator and
// the result consumer. The master modport is the upstream/downstream environment.
interface prod_accum_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH-1:0] p_in;
  logic               p_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               ovf;
  logic               drop;

  modport master (
    output p_in, p_valid, out_ready,
    input  in_ready, out_data, out_valid, ovf, drop
  );

  modport slave (
    input  p_in, p_valid, out_ready,
    output in_ready, out_data, out_valid, ovf, drop
  );
endinterface

// File: rtl/prod_accum.sv
// Sums ACC_LEN signed products, rounds half-up by 2^WIDTH and emits a WIDTH-bit result.
// Define PROD_ACCUM_SAT_EN to clip out-of-range results instead of wrapping them.
module prod_accum #(
  parameter int WIDTH   = 16,
  parameter int ACC_LEN = 8,
  parameter int GUARD   = 8
) (
  input logic         clk,
  input logic         rst_n,
  prod_accum_if.slave bus
);
  localparam int AW = 2*WIDTH + GUARD;
  localparam int RW = AW + 1 - WIDTH;
  localparam int CW = $clog2(ACC_LEN + 1);
  localparam logic [AW:0] RND = {{(AW+1-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [AW-1:0]    acc_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic             ovf_r;
  logic             drop_r;
  logic             in_ready_r;

  logic [AW-1:0]    p_ext_s;
  logic [AW-1:0]    sum_s;
  logic [AW:0]      rnd_sum_s;
  logic [RW-1:0]    r_s;
  logic [WIDTH-1:0] res_s;
  logic             res_ovf_s;
  logic             accept_s;
  logic             last_s;

  // True when the rounded value is representable in WIDTH signed bits.
  function automatic logic fits_width(input logic [RW-1:0] v);
    logic [RW-WIDTH:0] top;
    top = v[RW-1:WIDTH-1];
    return (top == {(RW-WIDTH+1){1'b0}}) || (top == {(RW-WIDTH+1){1'b1}});
  endfunction

  assign p_ext_s  = {{GUARD{bus.p_in[2*WIDTH-1]}}, bus.p_in};
  assign accept_s = bus.p_valid && in_ready_r;
  assign last_s   = accept_s && (cnt_r == CW'(ACC_LEN - 1));

  // Running sum including the current product, then round and range-reduce it.
  always_comb begin
    sum_s = {AW{1'b0}};
    if (state_r == ACC) begin
      sum_s = acc_r + p_ext_s;
    end else begin
      sum_s = p_ext_s;
    end
    // One extra bit keeps the rounding increment from wrapping the sum.
    rnd_sum_s = {sum_s[AW-1], sum_s} + RND;
    r_s       = rnd_sum_s[AW:WIDTH];
    res_ovf_s = !fits_width(r_s);
`ifdef PROD_ACCUM_SAT_EN
    if (res_ovf_s) begin
      res_s = r_s[RW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_s = r_s[WIDTH-1:0];
    end
`else
    res_s = r_s[WIDTH-1:0];
`endif
  end

  // Group FSM: accumulate, hold the result until taken, flag discarded products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {AW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      out_data_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      drop_r      <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      if (bus.p_valid && !in_ready_r) begin
        drop_r <= 1'b1;
      end
      case (state_r)
        IDLE, ACC: begin
          if (accept_s) begin
            acc_r <= sum_s;
            cnt_r <= cnt_r + CW'(1);
            if (last_s) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              out_data_r  <= res_s;
              ovf_r       <= res_ovf_s;
              in_ready_r  <= 1'b0;
            end else begin
              state_r    <= ACC;
              in_ready_r <= 1'b1;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_valid_r && bus.out_ready) begin
            state_r     <= IDLE;
            acc_r       <= {AW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          acc_r       <= {AW{1'b0}};
          cnt_r       <= {CW{1'b0}};
          out_valid_r <= 1'b0;
          ovf_r       <= 1'b0;
          in_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.ovf       = ovf_r;
  assign bus.drop      = drop_r;
endmodule

// File: tb/tb_prod_accum.sv
// Randomized and directed bench for prod_accum (WIDTH=16, ACC_LEN=4, GUARD=8)
// against an integer-arithmetic reference of the dot-product rounding rules.
module tb_prod_accum;
  logic clk;
  logic rst_n;
  int   checks_n;
  int   fails_n;
  logic drop_exp;
  logic [31:0] grp [4];

  prod_accum_if #(.WIDTH(16)) bus ();

  prod_accum #(.WIDTH(16), .ACC_LEN(4), .GUARD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      fails_n++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer sum, floor((sum + 2^15) / 2^16), then range handling.
  task automatic model(output logic [15:0] d, output logic o);
    longint s;
    longint r;
    s = 0;
    for (int i = 0; i < 4; i++) s += longint'($signed(grp[i]));
    r = (s + 64'sd32768) >>> 16;
    o = (r > 64'sd32767) || (r < -64'sd32768);
`ifdef PROD_ACCUM_SAT_EN
    if (r > 64'sd32767) d = 16'h7FFF;
    else if (r < -64'sd32768) d = 16'h8000;
    else d = r[15:0];
`else
    d = r[15:0];
`endif
  endtask

  task automatic run_group(input int gap, input int stall, input bit fixed,
                           input logic [15:0] fix_d, input logic fix_o);
    logic [15:0] exp_d;
    logic        exp_o;
    if (fixed) begin
      exp_d = fix_d;
      exp_o = fix_o;
    end else begin
      model(exp_d, exp_o);
    end
    check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check_eq("no_early_valid", 32'(bus.out_valid), 32'd0);
      bus.p_in    = grp[i];
      bus.p_valid = 1'b1;
      @(negedge clk);
      if (i < 3 && gap > 0) begin
        bus.p_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    bus.p_valid = 1'b0;
    check_eq("out_valid", 32'(bus.out_valid), 32'd1);
    check_eq("in_ready_done", 32'(bus.in_ready), 32'd0);
    check_eq("out_data", 32'(bus.out_data), 32'(exp_d));
    check_eq("ovf", 32'(bus.ovf), 32'(exp_o));
    for (int s = 0; s < stall; s++) begin
      if (s == 1) begin
        bus.p_in    = $urandom;
        bus.p_valid = 1'b1;
        drop_exp    = 1'b1;
      end
      @(negedge clk);
      bus.p_valid = 1'b0;
      check_eq("stall_data", 32'(bus.out_data), 32'(exp_d));
      check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
      check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    check_eq("drop", 32'(bus.drop), 32'(drop_exp));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("valid_cleared", 32'(bus.out_valid), 32'd0);
    check_eq("in_ready_after", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic set_all(input logic [31:0] p0, input logic [31:0] p1,
                         input logic [31:0] p2, input logic [31:0] p3);
    grp[0] = p0; grp[1] = p1; grp[2] = p2; grp[3] = p3;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
    check_eq("rst_drop", 32'(bus.drop), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    drop_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("in_ready_post_rst", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] p;
    checks_n      = 0;
    fails_n       = 0;
    drop_exp      = 1'b0;
    rst_n         = 1'b0;
    bus.p_in      = 32'h0;
    bus.p_valid   = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_eq("init_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("init_out_data", 32'(bus.out_data), 32'd0);
    check_eq("init_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("init_drop", 32'(bus.drop), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    set_all(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);
    run_group(0, 0, 1'b1, 16'h0004, 1'b0);
    set_all(32'h00008000, 32'h0, 32'h0, 32'h0);
    run_group(0, 0, 1'b1, 16'h0001, 1'b0);
    set_all(32'hFFFF7FFF, 32'h0, 32'h0, 32'h0);
    run_group(0, 0, 1'b1, 16'hFFFF, 1'b0);
    set_all(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
`ifdef PROD_ACCUM_SAT_EN
    run_group(0, 0, 1'b1, 16'h7FFF, 1'b1);
`else
    run_group(0, 0, 1'b1, 16'h0000, 1'b1);
`endif
    set_all(32'hC0000000, 32'hC0000000, 32'hC0000000, 32'hC0000000);
`ifdef PROD_ACCUM_SAT_EN
    run_group(0, 0, 1'b1, 16'h8000, 1'b1);
`else
    run_group(0, 0, 1'b1, 16'h0000, 1'b1);
`endif
    set_all(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);
    run_group(0, 3, 1'b1, 16'h0004, 1'b0);
    run_group(0, 0, 1'b1, 16'h0004, 1'b0);
    run_group(2, 0, 1'b1, 16'h0004, 1'b0);

    // Two accepted products, then an abandoning reset.
    for (int i = 0; i < 2; i++) begin
      bus.p_in    = 32'h00010000;
      bus.p_valid = 1'b1;
      @(negedge clk);
    end
    bus.p_valid = 1'b0;
    mid_reset();
    run_group(0, 0, 1'b1, 16'h0004, 1'b0);

    for (int g = 0; g < 25; g++) begin
      for (int i = 0; i < 4; i++) begin
        p = $urandom;
        if ($urandom_range(0, 1) == 1) p = {{12{p[19]}}, p[19:0]};
        grp[i] = p;
      end
      run_group(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, 16'h0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end
endmodule
